// File: rtl/input_layer_window_reader.sv
// AXI4 read master that streams 8-bit feature-map layers out of DDR and
// turns them into 3x3 stride-1 sliding windows (72-bit words), one layer
// after another. Write channels are present only for interconnect
// compatibility and are tied off.
module input_layer_window_reader #(
  parameter int C_S_AXI_ID_WIDTH   = 3,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int C_S_AXI_BURST_LEN  = 8,
  parameter int STREAM_DATA_WIDTH  = 72,
  parameter int MAX_COLS           = 256
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            Start,
  input  logic [31:0]                     axi_address,
  input  logic [7:0]                      no_of_input_layers,
  input  logic [9:0]                      input_layer_row_size,
  input  logic [9:0]                      input_layer_col_size,
  input  logic                            in_layer_ddr3_data_rdy,
  output logic [STREAM_DATA_WIDTH-1:0]    input_layer_1_data,
  output logic                            input_layer_1_valid,
  input  logic                            input_layer_1_rdy,
  output logic [7:0]                      input_layer_1_id,
  output logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_arid,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_axi_araddr,
  output logic [7:0]                      M_axi_arlen,
  output logic [2:0]                      M_axi_arsize,
  output logic [1:0]                      M_axi_arburst,
  output logic                            M_axi_arlock,
  output logic [3:0]                      M_axi_arcache,
  output logic [2:0]                      M_axi_arprot,
  output logic [3:0]                      M_axi_arqos,
  output logic                            M_axi_arvalid,
  input  logic                            M_axi_arready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_rid,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   M_axi_rdata,
  input  logic [1:0]                      M_axi_rresp,
  input  logic                            M_axi_rlast,
  input  logic                            M_axi_rvalid,
  output logic                            M_axi_rready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_awid,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_axi_awaddr,
  output logic [7:0]                      M_axi_awlen,
  output logic [2:0]                      M_axi_awsize,
  output logic [1:0]                      M_axi_awburst,
  output logic                            M_axi_awlock,
  output logic [3:0]                      M_axi_awcache,
  output logic [2:0]                      M_axi_awprot,
  output logic [3:0]                      M_axi_awqos,
  output logic                            M_axi_awvalid,
  input  logic                            M_axi_awready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   M_axi_wdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] M_axi_wstrb,
  output logic                            M_axi_wlast,
  output logic                            M_axi_wvalid,
  input  logic                            M_axi_wready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_bid,
  input  logic [1:0]                      M_axi_bresp,
  input  logic                            M_axi_bvalid,
  output logic                            M_axi_bready
);

  localparam int BYTES_PER_BEAT = C_S_AXI_DATA_WIDTH / 8;
  localparam int PIX_IDX_W      = $clog2(BYTES_PER_BEAT);
  localparam int LB_AW          = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int BEAT_W         = 18;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_RDY = 3'd1;
  localparam logic [2:0] S_AR       = 3'd2;
  localparam logic [2:0] S_R        = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;

  logic [2:0]                    state;
  logic [C_S_AXI_ADDR_WIDTH-1:0] cur_addr;
  logic [BEAT_W-1:0]             beats_total, beats_left, beats_calc;
  logic [7:0]                    layers_left, layer_id;
  logic [9:0]                    rows_q, cols_q;
  logic [19:0]                   pix_total;
  logic                          arvalid_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]                    arlen_q;

  logic [C_S_AXI_DATA_WIDTH-1:0] beat_buf;
  logic                          beat_vld;
  logic [PIX_IDX_W-1:0]          pix_idx;
  logic [9:0]                    row_cnt, col_cnt;
  logic                          pix_done;

  logic [7:0] lb0_mem [MAX_COLS];
  logic [7:0] lb1_mem [MAX_COLS];
  logic [7:0] win_p0  [3][3];
  logic [7:0] nwin    [3][3];
  logic [STREAM_DATA_WIDTH-1:0] win_word;
  logic [STREAM_DATA_WIDTH-1:0] data_p1;
  logic                         vld_p1;

  logic       r_hs, stall, adv, take, last_col, last_pix, win_edge;
  logic       start_job, layer_done, next_layer, new_layer;
  logic [7:0] pix;
  logic [7:0] lb_top, lb_mid;
  logic [LB_AW-1:0] lb_idx;
  logic       unused_inputs;

  assign unused_inputs = ^{M_axi_rid, M_axi_rresp, M_axi_awready, M_axi_wready,
                           M_axi_bid, M_axi_bresp, M_axi_bvalid};

  assign pix_total  = input_layer_row_size * input_layer_col_size;
  assign beats_calc = BEAT_W'((32'(pix_total) + 32'd7) >> 3);

  assign M_axi_rready = (state == S_R) && !beat_vld;
  assign r_hs         = M_axi_rvalid && M_axi_rready;
  assign stall        = vld_p1 && !input_layer_1_rdy;
  assign adv          = beat_vld && !stall;
  assign take         = adv && !pix_done;
  assign pix          = beat_buf[{pix_idx, 3'b000} +: 8];
  assign lb_idx       = col_cnt[LB_AW-1:0];
  assign lb_top       = lb0_mem[lb_idx];
  assign lb_mid       = lb1_mem[lb_idx];
  assign last_col     = (col_cnt == 10'(cols_q - 10'd1));
  assign last_pix     = last_col && (row_cnt == 10'(rows_q - 10'd1));
  assign win_edge     = (row_cnt >= 10'd2) && (col_cnt >= 10'd2);

  assign start_job  = (state == S_IDLE) && Start;
  assign layer_done = (state == S_DRAIN) && pix_done && !beat_vld && !stall;
  assign next_layer = layer_done && (layers_left != 8'd1);
  assign new_layer  = start_job || next_layer;

  // Sequence one burst at a time per layer and walk through the layers
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state       <= S_IDLE;
      cur_addr    <= '0;
      beats_total <= '0;
      beats_left  <= '0;
      layers_left <= '0;
      layer_id    <= '0;
      rows_q      <= '0;
      cols_q      <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
    end else begin
      case (state)
        S_IDLE: if (Start) begin
          rows_q      <= input_layer_row_size;
          cols_q      <= input_layer_col_size;
          layers_left <= no_of_input_layers;
          layer_id    <= '0;
          cur_addr    <= C_S_AXI_ADDR_WIDTH'(axi_address);
          beats_total <= beats_calc;
          beats_left  <= beats_calc;
          state       <= S_WAIT_RDY;
        end
        S_WAIT_RDY: if (in_layer_ddr3_data_rdy) begin
          arvalid_q <= 1'b1;
          araddr_q  <= cur_addr;
          arlen_q   <= (beats_left >= BEAT_W'(C_S_AXI_BURST_LEN)) ?
                       8'(C_S_AXI_BURST_LEN - 1) : 8'(beats_left[7:0] - 8'd1);
          state     <= S_AR;
        end
        S_AR: if (M_axi_arready) begin
          arvalid_q <= 1'b0;
          // Layers are packed back to back, so the next burst (or the next
          // layer's first burst) starts right after this one.
          cur_addr  <= cur_addr + C_S_AXI_ADDR_WIDTH'((32'(arlen_q) + 32'd1) * BYTES_PER_BEAT);
          state     <= S_R;
        end
        S_R: if (r_hs) begin
          beats_left <= beats_left - BEAT_W'(1);
          if (M_axi_rlast)
            state <= (beats_left == BEAT_W'(1)) ? S_DRAIN : S_WAIT_RDY;
        end
        S_DRAIN: if (layer_done) begin
          if (layers_left == 8'd1) begin
            state <= S_IDLE;
          end else begin
            layers_left <= layers_left - 8'd1;
            layer_id    <= layer_id + 8'd1;
            beats_left  <= beats_total;
            state       <= S_WAIT_RDY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Unpacker control: hold one beat, release one pixel per unstalled cycle
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      beat_vld <= 1'b0;
      pix_idx  <= '0;
      row_cnt  <= '0;
      col_cnt  <= '0;
      pix_done <= 1'b0;
    end else begin
      if (r_hs) begin
        beat_vld <= 1'b1;
        pix_idx  <= '0;
      end else if (adv) begin
        pix_idx <= pix_idx + PIX_IDX_W'(1);
        if (pix_idx == PIX_IDX_W'(BYTES_PER_BEAT - 1))
          beat_vld <= 1'b0;
      end
      // Pixels after the layer's last one are pad bytes and are dropped
      if (new_layer) begin
        row_cnt  <= '0;
        col_cnt  <= '0;
        pix_done <= 1'b0;
      end else if (take) begin
        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + 10'd1;
        end else begin
          col_cnt <= col_cnt + 10'd1;
        end
        if (last_pix)
          pix_done <= 1'b1;
      end
    end
  end

  // Beat capture register (data only)
  always_ff @(posedge clk) begin
    if (r_hs)
      beat_buf <= M_axi_rdata;
  end

  // Next window: shift left one column, new column is (r-2, r-1, r) at c
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nwin[i][0] = win_p0[i][1];
      nwin[i][1] = win_p0[i][2];
    end
    nwin[0][2] = lb_top;
    nwin[1][2] = lb_mid;
    nwin[2][2] = pix;
    win_word = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        win_word[8*(3*(2-j)+i) +: 8] = nwin[i][j];
  end

  // ---- stage p0: line buffers and 3x3 window register ----
  always_ff @(posedge clk) begin
    if (take) begin
      lb0_mem[lb_idx] <= lb_mid;
      lb1_mem[lb_idx] <= pix;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win_p0[i][j] <= nwin[i][j];
    end
  end

  // ---- stage p1: registered stream output, held while stalled ----
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (!stall) begin
      vld_p1 <= take && win_edge;
      if (take && win_edge)
        data_p1 <= win_word;
    end
  end

  assign input_layer_1_data  = data_p1;
  assign input_layer_1_valid = vld_p1;
  assign input_layer_1_id    = layer_id;

  assign M_axi_arid    = '0;
  assign M_axi_araddr  = araddr_q;
  assign M_axi_arlen   = arlen_q;
  assign M_axi_arsize  = 3'($clog2(BYTES_PER_BEAT));
  assign M_axi_arburst = 2'b01;
  assign M_axi_arlock  = 1'b0;
  assign M_axi_arcache = 4'b0011;
  assign M_axi_arprot  = 3'b000;
  assign M_axi_arqos   = 4'b0000;
  assign M_axi_arvalid = arvalid_q;

  assign M_axi_awid    = '0;
  assign M_axi_awaddr  = '0;
  assign M_axi_awlen   = '0;
  assign M_axi_awsize  = '0;
  assign M_axi_awburst = 2'b01;
  assign M_axi_awlock  = 1'b0;
  assign M_axi_awcache = 4'b0011;
  assign M_axi_awprot  = 3'b000;
  assign M_axi_awqos   = 4'b0000;
  assign M_axi_awvalid = 1'b0;
  assign M_axi_wdata   = '0;
  assign M_axi_wstrb   = '0;
  assign M_axi_wlast   = 1'b0;
  assign M_axi_wvalid  = 1'b0;
  assign M_axi_bready  = 1'b1;

endmodule

// File: tb/tb_input_layer_window_reader.sv
// Bench for input_layer_window_reader: behavioural AXI read slave backed by
// a synthetic memory, scoreboard of expected ARs and windows per job.
module tb_input_layer_window_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        Start;
  logic [31:0] axi_address;
  logic [7:0]  no_of_input_layers;
  logic [9:0]  input_layer_row_size, input_layer_col_size;
  logic        in_layer_ddr3_data_rdy;
  logic [71:0] input_layer_1_data;
  logic        input_layer_1_valid;
  logic        input_layer_1_rdy;
  logic [7:0]  input_layer_1_id;
  logic [2:0]  M_axi_arid, M_axi_rid, M_axi_awid, M_axi_bid;
  logic [31:0] M_axi_araddr, M_axi_awaddr;
  logic [7:0]  M_axi_arlen, M_axi_awlen;
  logic [2:0]  M_axi_arsize, M_axi_arprot, M_axi_awsize, M_axi_awprot;
  logic [1:0]  M_axi_arburst, M_axi_awburst, M_axi_rresp, M_axi_bresp;
  logic        M_axi_arlock, M_axi_awlock;
  logic [3:0]  M_axi_arcache, M_axi_arqos, M_axi_awcache, M_axi_awqos;
  logic        M_axi_arvalid, M_axi_arready;
  logic [63:0] M_axi_rdata, M_axi_wdata;
  logic        M_axi_rlast, M_axi_rvalid, M_axi_rready;
  logic        M_axi_awvalid, M_axi_awready;
  logic [7:0]  M_axi_wstrb;
  logic        M_axi_wlast, M_axi_wvalid, M_axi_wready;
  logic        M_axi_bvalid, M_axi_bready;

  always #5 clk = ~clk;

  input_layer_window_reader dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .axi_address(axi_address),
    .no_of_input_layers(no_of_input_layers),
    .input_layer_row_size(input_layer_row_size),
    .input_layer_col_size(input_layer_col_size),
    .in_layer_ddr3_data_rdy(in_layer_ddr3_data_rdy),
    .input_layer_1_data(input_layer_1_data), .input_layer_1_valid(input_layer_1_valid),
    .input_layer_1_rdy(input_layer_1_rdy), .input_layer_1_id(input_layer_1_id),
    .M_axi_arid(M_axi_arid), .M_axi_araddr(M_axi_araddr), .M_axi_arlen(M_axi_arlen),
    .M_axi_arsize(M_axi_arsize), .M_axi_arburst(M_axi_arburst), .M_axi_arlock(M_axi_arlock),
    .M_axi_arcache(M_axi_arcache), .M_axi_arprot(M_axi_arprot), .M_axi_arqos(M_axi_arqos),
    .M_axi_arvalid(M_axi_arvalid), .M_axi_arready(M_axi_arready),
    .M_axi_rid(M_axi_rid), .M_axi_rdata(M_axi_rdata), .M_axi_rresp(M_axi_rresp),
    .M_axi_rlast(M_axi_rlast), .M_axi_rvalid(M_axi_rvalid), .M_axi_rready(M_axi_rready),
    .M_axi_awid(M_axi_awid), .M_axi_awaddr(M_axi_awaddr), .M_axi_awlen(M_axi_awlen),
    .M_axi_awsize(M_axi_awsize), .M_axi_awburst(M_axi_awburst), .M_axi_awlock(M_axi_awlock),
    .M_axi_awcache(M_axi_awcache), .M_axi_awprot(M_axi_awprot), .M_axi_awqos(M_axi_awqos),
    .M_axi_awvalid(M_axi_awvalid), .M_axi_awready(M_axi_awready),
    .M_axi_wdata(M_axi_wdata), .M_axi_wstrb(M_axi_wstrb), .M_axi_wlast(M_axi_wlast),
    .M_axi_wvalid(M_axi_wvalid), .M_axi_wready(M_axi_wready),
    .M_axi_bid(M_axi_bid), .M_axi_bresp(M_axi_bresp), .M_axi_bvalid(M_axi_bvalid),
    .M_axi_bready(M_axi_bready)
  );

  typedef struct { logic [71:0] data; logic [7:0] id; } win_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;

  win_t exp_win[$];
  ar_t  exp_ar[$];
  ar_t  rd_q[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          mem_mode = 0;
  logic [31:0] mem_base = 32'h0;
  logic        bp_rand  = 1'b0;
  logic        axi_rand = 1'b0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Synthetic DDR contents
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] o, h;
    o = a - mem_base;
    if (mem_mode == 0) return o[7:0];
    h = o * 32'h9E3779B1;
    return h[23:16] ^ o[7:0];
  endfunction

  function automatic logic [71:0] exp_word(input logic [31:0] lbase, input int cols,
                                           input int r, input int c);
    logic [7:0] p [3][3];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = mem_byte(lbase + 32'((r - 2 + i) * cols + (c - 2 + j)));
    return {p[2][0], p[1][0], p[0][0], p[2][1], p[1][1], p[0][1], p[2][2], p[1][2], p[0][2]};
  endfunction

  task automatic load_job(input logic [31:0] base, input int layers, input int rows, input int cols);
    int   lsz, beats, rem, b;
    ar_t  a;
    win_t w;
    logic [31:0] lbase;
    lsz   = ((rows * cols + 7) / 8) * 8;
    beats = lsz / 8;
    for (int k = 0; k < layers; k++) begin
      lbase = base + 32'(k * lsz);
      rem = beats;
      b = 0;
      while (rem > 0) begin
        a.addr = lbase + 32'(64 * b);
        a.len  = 8'(((rem > 8) ? 8 : rem) - 1);
        exp_ar.push_back(a);
        rem -= (rem > 8) ? 8 : rem;
        b++;
      end
      for (int r = 2; r < rows; r++)
        for (int c = 2; c < cols; c++) begin
          w.data = exp_word(lbase, cols, r, c);
          w.id   = 8'(k);
          exp_win.push_back(w);
        end
    end
  endtask

  task automatic pulse_start(input logic [31:0] base, input int layers, input int rows, input int cols);
    @(posedge clk); #1;
    axi_address          = base;
    no_of_input_layers   = 8'(layers);
    input_layer_row_size = 10'(rows);
    input_layer_col_size = 10'(cols);
    Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
  endtask

  task automatic start_job(input logic [31:0] base, input int layers, input int rows, input int cols);
    load_job(base, layers, rows, cols);
    pulse_start(base, layers, rows, cols);
  endtask

  task automatic wait_job(input string tag, input int bound);
    int cyc;
    cyc = 0;
    while ((exp_win.size() != 0 || exp_ar.size() != 0) && cyc < bound) begin
      @(posedge clk);
      cyc++;
    end
    chk({tag, " windows_left"}, 72'(exp_win.size()), 72'd0);
    chk({tag, " ars_left"}, 72'(exp_ar.size()), 72'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk({tag, " idle_valid"}, 72'(input_layer_1_valid), 72'd0);
    chk({tag, " idle_arvalid"}, 72'(M_axi_arvalid), 72'd0);
    if (cyc >= bound) begin
      exp_win.delete();
      exp_ar.delete();
      #2 reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b0;
    end
  endtask

  // AXI read slave, downstream sink and scoreboard monitor
  logic        r_hs;
  logic        prev_stall;
  logic [71:0] prev_data;
  logic [7:0]  prev_id;
  int          beat_i;
  initial begin
    ar_t  a;
    win_t w;
    r_hs = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_id = '0; beat_i = 0;
    M_axi_arready = 1'b1; M_axi_rvalid = 1'b0; M_axi_rdata = '0; M_axi_rlast = 1'b0;
    M_axi_rid = '0; M_axi_rresp = '0; input_layer_1_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        rd_q.delete();
        beat_i = 0;
        r_hs = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 72'(input_layer_1_valid), 72'd1);
          chk("stall_data", input_layer_1_data, prev_data);
          chk("stall_id", 72'(input_layer_1_id), 72'(prev_id));
        end
        prev_stall = input_layer_1_valid && !input_layer_1_rdy;
        prev_data  = input_layer_1_data;
        prev_id    = input_layer_1_id;
        if (M_axi_arvalid && M_axi_arready) begin
          chk("ar_expected", 72'(exp_ar.size() > 0), 72'd1);
          if (exp_ar.size() > 0) begin
            a = exp_ar.pop_front();
            chk("araddr", 72'(M_axi_araddr), 72'(a.addr));
            chk("arlen", 72'(M_axi_arlen), 72'(a.len));
          end
          chk("arsize", 72'(M_axi_arsize), 72'd3);
          chk("arburst", 72'(M_axi_arburst), 72'd1);
          a.addr = M_axi_araddr;
          a.len  = M_axi_arlen;
          rd_q.push_back(a);
        end
        if (input_layer_1_valid && input_layer_1_rdy) begin
          chk("win_expected", 72'(exp_win.size() > 0), 72'd1);
          if (exp_win.size() > 0) begin
            w = exp_win.pop_front();
            chk("win_data", input_layer_1_data, w.data);
            chk("win_id", 72'(input_layer_1_id), 72'(w.id));
          end
        end
        r_hs = M_axi_rvalid && M_axi_rready;
      end
      @(posedge clk); #1;
      if (r_hs && rd_q.size() > 0) begin
        if (beat_i == int'(rd_q[0].len)) begin
          void'(rd_q.pop_front());
          beat_i = 0;
        end else begin
          beat_i++;
        end
      end
      if (reset_n) begin
        M_axi_rvalid = 1'b0;
      end else if (!(M_axi_rvalid && !r_hs)) begin
        if (rd_q.size() > 0 && (!axi_rand || $urandom_range(2) != 0)) begin
          M_axi_rvalid = 1'b1;
          M_axi_rlast  = (beat_i == int'(rd_q[0].len));
          M_axi_rresp  = 2'($urandom_range(3));
          for (int n = 0; n < 8; n++)
            M_axi_rdata[8*n +: 8] = mem_byte(rd_q[0].addr + 32'(8 * beat_i + n));
        end else begin
          M_axi_rvalid = 1'b0;
        end
      end
      M_axi_arready     = !axi_rand || ($urandom_range(2) == 0);
      input_layer_1_rdy = !bp_rand || ($urandom_range(3) != 0);
    end
  end

  initial begin
    int ar_cnt, t;
    reset_n = 1'b1; Start = 1'b0; axi_address = '0; no_of_input_layers = '0;
    input_layer_row_size = '0; input_layer_col_size = '0; in_layer_ddr3_data_rdy = 1'b1;
    M_axi_awready = 1'b0; M_axi_wready = 1'b0; M_axi_bid = '0; M_axi_bresp = '0;
    M_axi_bvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 72'(input_layer_1_valid), 72'd0);
    chk("rst_data", input_layer_1_data, 72'd0);
    chk("rst_id", 72'(input_layer_1_id), 72'd0);
    chk("rst_arvalid", 72'(M_axi_arvalid), 72'd0);
    chk("rst_rready", 72'(M_axi_rready), 72'd0);
    chk("rst_araddr", 72'(M_axi_araddr), 72'd0);
    chk("rst_arlen", 72'(M_axi_arlen), 72'd0);
    chk("tie_bready", 72'(M_axi_bready), 72'd1);
    chk("tie_arcache", 72'(M_axi_arcache), 72'd3);
    @(posedge clk); #1 reset_n = 1'b0;

    // 4x4 single layer, pixel n = n
    mem_mode = 0; mem_base = 32'h1000;
    start_job(32'h1000, 1, 4, 4);
    wait_job("c2_4x4", 500);

    // DDR not ready for 100 cycles; two layers with pad bytes
    mem_mode = 1; mem_base = 32'h0;
    in_layer_ddr3_data_rdy = 1'b0;
    start_job(32'h2000, 2, 5, 7);
    ar_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (M_axi_arvalid) ar_cnt++;
    end
    chk("ar_while_ddr_not_rdy", 72'(ar_cnt), 72'd0);
    @(posedge clk); #1 in_layer_ddr3_data_rdy = 1'b1;
    wait_job("c5_ddr_rdy", 2000);

    // Asynchronous reset in the middle of a job
    start_job(32'h4000, 1, 16, 16);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!input_layer_1_valid && t < 300);
    chk("pre_rst_valid", 72'(input_layer_1_valid), 72'd1);
    #2 reset_n = 1'b1;
    #1;
    chk("async_rst_valid", 72'(input_layer_1_valid), 72'd0);
    chk("async_rst_arvalid", 72'(M_axi_arvalid), 72'd0);
    chk("async_rst_rready", 72'(M_axi_rready), 72'd0);
    chk("async_rst_data", input_layer_1_data, 72'd0);
    exp_win.delete();
    exp_ar.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    axi_rand = 1'b1; bp_rand = 1'b1;
    start_job(32'h8000, 3, 6, 10);
    wait_job("post_rst", 3000);

    // 5 layers 49x49 with backpressure, random AXI timing, stray Starts
    start_job(32'h1000, 5, 49, 49);
    repeat (300) @(posedge clk);
    pulse_start(32'hDEAD_0000, 2, 7, 9);
    repeat (4000) @(posedge clk);
    pulse_start(32'h0000_0040, 1, 3, 3);
    wait_job("c3_49x49", 50000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_layer_window_reader.md
Name: input_layer_window_reader

Overview:
- AXI4 read master that fetches 8-bit feature-map layers from DDR and emits 3x3 sliding windows as 72-bit stream words.
- Windows use stride 1 and no padding, giving (rows-2)*(cols-2) windows per layer.
- Sits between the DDR3 AXI slave and the first convolution stage.
- The write channels exist for interconnect compatibility only and are tied off.

Parameters:
- C_S_AXI_ID_WIDTH, 3: AXI ID width.
- C_S_AXI_ADDR_WIDTH, 32: AXI address width.
- C_S_AXI_DATA_WIDTH, 64: AXI data width; 8 pixels per beat.
- C_S_AXI_BURST_LEN, 8: maximum beats per read burst.
- STREAM_DATA_WIDTH, 72: window word width (9 x 8 bits).
- MAX_COLS, 256: line-buffer depth; col size must not exceed it.

Ports:
- clk in 1: single clock, rising edge.
- reset_n in 1: asynchronous, active-high reset (asserted = 1); the legacy name is kept.
- Start in 1: one-cycle start pulse; honoured only in IDLE.
- axi_address in 32: byte base address of layer 0; 8-byte aligned.
- no_of_input_layers in 8: number of layers, 1..255.
- input_layer_row_size in 10: rows per layer, >=3.
- input_layer_col_size in 10: columns per layer, 3..MAX_COLS.
- in_layer_ddr3_data_rdy in 1: DDR data ready; gates issue of each AR.
- input_layer_1_data out 72: window word.
- input_layer_1_valid out 1: window valid.
- input_layer_1_rdy in 1: downstream ready.
- input_layer_1_id out 8: index of the current layer.
- M_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,valid} out: AXI4 read-address channel; M_axi_arready in.
- M_axi_r{id,data(64),resp,last,valid} in; M_axi_rready out: AXI4 read-data channel.
- M_axi_aw*/w* outputs, M_axi_bready out; M_axi_awready/wready/bid/bresp/bvalid in: write channels, tied off.

Behaviour:
- Reset: all outputs 0 (data, valid, id, arvalid, rready, araddr, arlen); FSM goes to IDLE. A reset mid-burst abandons the burst.
- Tie-offs: awvalid=0, wvalid=0, wlast=0, bready=1, arid=0, arsize=3, arburst=INCR(01), arlock=0, arcache=4'b0011, arprot=0, arqos=0.
- Memory layout:
  - Layer k is row-major and byte-packed at axi_address + k*L, where L = rows*cols rounded up to a multiple of 8.
  - Byte order is little-endian: pixel n of a beat is rdata[8n+7:8n].
- FSM:
  - IDLE -> WAIT_RDY on Start.
  - WAIT_RDY -> AR when in_layer_ddr3_data_rdy=1.
  - AR holds arvalid until arready, then -> R.
  - R accepts beats; on rlast -> WAIT_RDY if beats remain in the layer, else DRAIN.
  - DRAIN -> next layer (WAIT_RDY, id+1) or IDLE after the last layer's final window is accepted.
  - Exactly one burst is outstanding at a time.
- Burst sizing: arlen = min(8, remaining beats) - 1; araddr advances by 64 per burst. rresp is ignored.
- Unpacker:
  - Holds one beat; rready=1 only when the unpacker is empty and in state R.
  - Shifts out one pixel per cycle when not stalled.
  - Discards pad bytes beyond rows*cols.
- Window formation:
  - Two line buffers of cols entries plus a 3x3 register window.
  - Pixel (r,c) shifts in as the new rightmost column: (r-2,c), (r-1,c), (r,c).
  - A window is emitted when r>=2 and c>=2; win_i_j = pixel(r-2+i, c-2+j).
- Word packing (byte b = data[8b+7:8b]):
  - b8=win_2_0, b7=win_1_0, b6=win_0_0
  - b5=win_2_1, b4=win_1_1, b3=win_0_1
  - b2=win_2_2, b1=win_1_2, b0=win_0_2
- Handshake:
  - data and valid are registered.
  - When valid=1 and rdy=0, data, valid and id hold and the whole pipeline stalls. No loss or duplication is permitted.
  - A transfer occurs on valid & rdy.
- Layer boundaries: row/col counters clear per layer. id changes only after the layer's last window transfers.
- Start outside IDLE is ignored. Parameters are sampled at Start.

Test Plan:
1. Reset asserted mid-operation -> valid, arvalid, rready, data go to 0 asynchronously. Start after release runs a full job.
2. 1 layer, 4x4, base 0x1000, pixel n = n, rdy=1:
   - One AR: addr 0x1000, arlen 1, arsize 3.
   - 4 windows; first window = 72'h08_04_00_09_05_01_0A_06_02.
   - Last window = 72'h0D_09_05_0E_0A_06_0F_0B_07; id=0.
3. 5 layers, 49x49, base 0x1000:
   - 2209 windows per layer, 11045 total; id 0..4.
   - Layer k base = 0x1000 + k*2408.
   - Per layer: 38 ARs, 37 with arlen 7 and the last with arlen 4.
4. Random rdy backpressure on case 3 -> identical window sequence; data stable while stalled.
5. in_layer_ddr3_data_rdy held 0 for 100 cycles after Start -> no arvalid until it rises, then normal output.
6. Random arready/rvalid delays -> same outputs as case 2/3. Start pulse during a run -> ignored.
